// File: rtl/hcsr04_responder.sv
// hcsr04_responder: sensor end of an HC-SR04 trig/echo link.
// Accepts a trigger pulse, waits a fixed burst delay, then drives an echo pulse whose
// width is clamp(distance_cm) * CYC_PER_CM clocks, or TIMEOUT_CYC when no object is present.
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  synchronous active-low reset
//   hctrig_export  trigger from processor PIO (asynchronous, synchronized here)
//   distance_cm    simulated distance in cm, sampled on the trigger fall cycle
//   obj_present    0 = no target, echo uses the timeout width
//   hcecho_export  echo pulse to processor PIO
//   busy           high while in DELAY/ECHO/HOLDOFF
//   trig_err       one-cycle pulse: trigger shorter than TRIG_MIN_CYC
//   trig_ignored   one-cycle pulse: trigger rise seen while busy
module hcsr04_responder #(
  parameter int unsigned TRIG_MIN_CYC    = 500,
  parameter int unsigned BURST_DELAY_CYC = 23000,
  parameter int unsigned CYC_PER_CM      = 2900,
  parameter int unsigned MIN_CM          = 2,
  parameter int unsigned MAX_CM          = 400,
  parameter int unsigned TIMEOUT_CYC     = 1900000,
  parameter int unsigned HOLDOFF_CYC     = 500000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       hctrig_export,
  input  logic [8:0] distance_cm,
  input  logic       obj_present,
  output logic       hcecho_export,
  output logic       busy,
  output logic       trig_err,
  output logic       trig_ignored
);

  localparam int unsigned HiW    = $clog2(TRIG_MIN_CYC + 1);
  localparam int unsigned DlyW   = $clog2(BURST_DELAY_CYC + 1);
  localparam int unsigned HoldW  = $clog2(HOLDOFF_CYC + 1);
  localparam int unsigned CmW    = $clog2(MAX_CM + 1);
  // The sub-cycle counter doubles as the flat timeout counter when no object is present.
  localparam int unsigned SubMax = (TIMEOUT_CYC > CYC_PER_CM) ? TIMEOUT_CYC : CYC_PER_CM;
  localparam int unsigned SubW   = $clog2(SubMax + 1);

  localparam logic [HiW-1:0]   HiMin    = HiW'(TRIG_MIN_CYC);
  localparam logic [DlyW-1:0]  DlyLast  = DlyW'(BURST_DELAY_CYC - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF_CYC - 1);
  localparam logic [SubW-1:0]  CpcLast  = SubW'(CYC_PER_CM - 1);
  localparam logic [SubW-1:0]  ToLast   = SubW'(TIMEOUT_CYC - 1);
  localparam logic [8:0]       MinCm    = 9'(MIN_CM);
  localparam logic [8:0]       MaxCm    = 9'(MAX_CM);

  typedef enum logic [2:0] {
    StIdle,
    StTrigHi,
    StDelay,
    StEcho,
    StHoldoff
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, trig_s_q, trig_d_q;
  logic [HiW-1:0]   hi_cnt_q, hi_cnt_d;
  logic [DlyW-1:0]  dly_cnt_q, dly_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CmW-1:0]   cm_cnt_q, cm_cnt_d;
  logic [SubW-1:0]  sub_cnt_q, sub_cnt_d;
  logic             obj_q, obj_d;
  logic             echo_q, echo_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             ign_q, ign_d;

  logic             trig_rise, trig_fall;
  logic [8:0]       dist_clamped;
  logic [SubW-1:0]  sub_last;

  assign trig_rise = trig_s_q & ~trig_d_q;
  assign trig_fall = ~trig_s_q & trig_d_q;
  assign sub_last  = obj_q ? CpcLast : ToLast;

  always_comb begin
    if (distance_cm < MinCm) begin
      dist_clamped = MinCm;
    end else if (distance_cm > MaxCm) begin
      dist_clamped = MaxCm;
    end else begin
      dist_clamped = distance_cm;
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_cnt_d   = hi_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    hold_cnt_d = hold_cnt_q;
    cm_cnt_d   = cm_cnt_q;
    sub_cnt_d  = sub_cnt_q;
    obj_d      = obj_q;
    echo_d     = echo_q;
    err_d      = 1'b0;
    ign_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Edge-based entry: a trigger still high from a busy period is never accepted.
        if (trig_rise) begin
          state_d  = StTrigHi;
          hi_cnt_d = HiW'(1);
        end
      end
      StTrigHi: begin
        if (trig_fall) begin
          if (hi_cnt_q >= HiMin) begin
            state_d   = StDelay;
            // The fall cycle itself counts as the first delay clock.
            dly_cnt_d = DlyW'(1);
            obj_d     = obj_present;
            cm_cnt_d  = obj_present ? CmW'(dist_clamped) : CmW'(1);
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end else if (trig_s_q && (hi_cnt_q != HiMin)) begin
          hi_cnt_d = hi_cnt_q + HiW'(1);
        end
      end
      StDelay: begin
        ign_d = trig_rise;
        if (dly_cnt_q >= DlyLast) begin
          state_d   = StEcho;
          echo_d    = 1'b1;
          sub_cnt_d = '0;
        end else begin
          dly_cnt_d = dly_cnt_q + DlyW'(1);
        end
      end
      StEcho: begin
        ign_d = trig_rise;
        if (sub_cnt_q == sub_last) begin
          sub_cnt_d = '0;
          cm_cnt_d  = cm_cnt_q - CmW'(1);
          if (cm_cnt_q == CmW'(1)) begin
            state_d    = StHoldoff;
            echo_d     = 1'b0;
            hold_cnt_d = '0;
          end
        end else begin
          sub_cnt_d = sub_cnt_q + SubW'(1);
        end
      end
      StHoldoff: begin
        ign_d = trig_rise;
        if (hold_cnt_q >= HoldLast) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        echo_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == StDelay) || (state_d == StEcho) || (state_d == StHoldoff);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b0;
      trig_s_q   <= 1'b0;
      trig_d_q   <= 1'b0;
      hi_cnt_q   <= '0;
      dly_cnt_q  <= '0;
      hold_cnt_q <= '0;
      cm_cnt_q   <= '0;
      sub_cnt_q  <= '0;
      obj_q      <= 1'b0;
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      ign_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= hctrig_export;
      trig_s_q   <= sync1_q;
      trig_d_q   <= trig_s_q;
      hi_cnt_q   <= hi_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      cm_cnt_q   <= cm_cnt_d;
      sub_cnt_q  <= sub_cnt_d;
      obj_q      <= obj_d;
      echo_q     <= echo_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      ign_q      <= ign_d;
    end
  end

  assign hcecho_export = echo_q;
  assign busy          = busy_q;
  assign trig_err      = err_q;
  assign trig_ignored  = ign_q;

endmodule
